// File: rtl/compteur_bloc_pkg.sv
// ascon_pack: shared types and constants for the ASCON-128 block counter
package ascon_pack;
  localparam int CPT_BLOC_WIDTH = 2;
  typedef logic [CPT_BLOC_WIDTH-1:0] cpt_bloc_t;
  localparam cpt_bloc_t CPT_BLOC_MAX = 2'd3;
endpackage

// File: rtl/compteur_bloc.sv
// compteur_bloc: 2-bit block counter with sync clear, increment and terminal-count flag
//   clock_i  : system clock, rising edge
//   resetb_i : async active-low reset, clears count
//   enable_i : increment request
//   init_i   : sync clear, priority over enable_i
//   cpt_o    : registered block count
//   last_o   : high while cpt_o == CPT_MAX
//   COMPTEUR_BLOC_SAT_EN : saturate at CPT_MAX instead of wrapping to 0
module compteur_bloc
  import ascon_pack::*;
#(
  parameter int CPT_MAX = int'(CPT_BLOC_MAX)
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      enable_i,
  input  logic      init_i,
  output cpt_bloc_t cpt_o,
  output logic      last_o
);
  if (CPT_MAX < 1 || CPT_MAX > int'(CPT_BLOC_MAX)) begin : g_bad_max
    $error("compteur_bloc: CPT_MAX must be in 1..3");
  end
  localparam cpt_bloc_t MAX_C = cpt_bloc_t'(CPT_MAX);
  cpt_bloc_t cpt_q, cpt_d, inc;
  logic last;
  assign last = (cpt_q == MAX_C);
`ifdef COMPTEUR_BLOC_SAT_EN
  assign inc = last ? cpt_q : cpt_q + 1'b1;
`else
  assign inc = last ? '0 : cpt_q + 1'b1;
`endif
  always_comb begin
    cpt_d = init_i ? '0 : (enable_i ? inc : cpt_q);
  end
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) cpt_q <= '0;
    else cpt_q <= cpt_d;
  end
  assign cpt_o  = cpt_q;
  assign last_o = last;
endmodule

// File: tb/tb_compteur_bloc.sv
// tb_compteur_bloc: self-checking bench for compteur_bloc against an arithmetic count model
module tb_compteur_bloc;
  import ascon_pack::*;
  localparam int MAX = 3;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic en = 1'b0;
  logic ini = 1'b0;
  cpt_bloc_t cpt;
  logic last;
  int n = 0;
  int nf = 0;
  int exp_c = 0;
  compteur_bloc #(.CPT_MAX(MAX)) dut (
    .clock_i(clk),
    .resetb_i(rstb),
    .enable_i(en),
    .init_i(ini),
    .cpt_o(cpt),
    .last_o(last)
  );
  always #5 clk = ~clk;
  function automatic int model(int c, bit i, bit e);
    if (i) return 0;
    if (!e) return c;
`ifdef COMPTEUR_BLOC_SAT_EN
    return (c + 1 > MAX) ? MAX : c + 1;
`else
    return (c + 1) % (MAX + 1);
`endif
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n++;
    assert (obs === expv) else begin
      nf++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic check_out(string tag);
    chk({tag, "_cpt"}, {30'd0, cpt}, exp_c);
    chk({tag, "_last"}, {31'd0, last}, (exp_c == MAX) ? 1 : 0);
  endtask
  task automatic step(bit i, bit e, string tag);
    ini = i;
    en = e;
    @(posedge clk);
    exp_c = model(exp_c, i, e);
    #1 check_out(tag);
  endtask
  task automatic mid_reset(string tag);
    #2 rstb = 1'b0;
    exp_c = 0;
    #1 check_out(tag);
    #1 rstb = 1'b1;
  endtask
  initial begin
    int seq[5];
`ifdef COMPTEUR_BLOC_SAT_EN
    seq = '{1, 2, 3, 3, 3};
`else
    seq = '{1, 2, 3, 0, 1};
`endif
    #12 check_out("reset_hold");
    @(negedge clk) rstb = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, "init_dom");
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, "count");
      chk("count_seq", {30'd0, cpt}, seq[k]);
    end
    step(1'b1, 1'b0, "clear");
    step(1'b0, 1'b1, "to2");
    step(1'b0, 1'b1, "to2");
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, "hold");
      chk("hold_val", {30'd0, cpt}, 2);
    end
    step(1'b1, 1'b0, "init_pulse");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, "to3");
    mid_reset("async_rst");
    step(1'b0, 1'b1, "restart");
    chk("restart_val", {30'd0, cpt}, 1);
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), "rand");
      if ($urandom_range(0, 24) == 0) mid_reset("rand_rst");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule

// File: doc/compteur_bloc.md
# compteur_bloc

Block counter for the ASCON-128 datapath. It counts processed data blocks so the FSM can select the associated-data/plaintext/tag phases. It provides a 2-bit count with synchronous clear (`init_i`) and increment (`enable_i`), plus a terminal-count flag. It sits beside the ASCON control FSM, which drives `init_i`/`enable_i` and decodes `cpt_o`.

## Interface
- `CPT_MAX`, default 3 (`ascon_pack::CPT_BLOC_MAX`): terminal count value; legal range 1..3.
- `clock_i`  in  1  single system clock; all state updates on its rising edge.
- `resetb_i`  in  1  reset, asynchronous and active-low; clears all state immediately.
- `enable_i`  in  1  increment request; sampled on the rising edge of `clock_i`.
- `init_i`  in  1  synchronous clear to 0; has priority over `enable_i`.
- `cpt_o`  out  2  current block count, type `ascon_pack::cpt_bloc_t`; registered.
- `last_o`  out  1  high when `cpt_o == CPT_MAX`; combinational decode of the register.

## Operation
- Next-state priority, evaluated at each rising edge while `resetb_i = 1`:
  1. `init_i = 1`: counter loads 0, whatever `enable_i` is.
  2. `init_i = 0`, `enable_i = 1`: counter increments by 1.
  3. Both 0: counter holds.
- Wrap-around with the default build: an increment when `cpt_o == CPT_MAX` loads 0.
- Arithmetic is unsigned and 2 bits wide. No carry or overflow output.
- `last_o` = (`cpt_o == CPT_MAX`). It follows the register with no extra cycle.
- No FSM inside the block; the only state is the count register.

## Timing
- Reset values: `cpt_o = 0`, `last_o = 0` (for `CPT_MAX ≠ 0`).
- Reset assertion clears the count immediately, with no clock needed. This includes reset in the middle of counting.
- Reset deassertion: the first update happens on the next rising edge after `resetb_i` goes high.
- Latency: one clock from `enable_i`/`init_i` sampled to `cpt_o` updated. `last_o` changes in the same cycle as `cpt_o`.
- `init_i` and `enable_i` both high on the same edge: the result is 0, and the counter stays at 0 for as long as both stay high.
- Inputs must be synchronous to `clock_i` and must meet setup/hold at the rising edge.

## Configuration
- Macro `COMPTEUR_BLOC_SAT_EN`.
  - Defined: the counter saturates. An increment at `CPT_MAX` holds the value at `CPT_MAX`, and `last_o` stays high until `init_i` or reset.
  - Undefined (default): modulo wrap to 0 after `CPT_MAX`, as described in Operation.
  - `init_i` priority and reset behaviour are the same in both builds.

## Structure
- `ascon_pack` holds:
  - `localparam int CPT_BLOC_WIDTH = 2`
  - `typedef logic [CPT_BLOC_WIDTH-1:0] cpt_bloc_t`
  - `localparam cpt_bloc_t CPT_BLOC_MAX = 2'd3`
- Single module with no sub-module.
- Structure of the module:
  - one `always_ff` sensitive to `posedge clock_i` / `negedge resetb_i`;
  - a combinational next-state and `last_o` decode;
  - elaboration-time checks on the legal range of `CPT_MAX`.

## Test plan
- Reset: hold `resetb_i = 0` for 10 ns with the clock running -> `cpt_o = 0`, `last_o = 0`. Assert reset mid-cycle -> `cpt_o` goes to 0 before the next edge.
- Init dominance: `enable_i = 1`, `init_i = 1` for 3 edges after reset release -> `cpt_o` stays 0 on every edge.
- Count/wrap: `init_i = 0`, `enable_i = 1` for 5 edges -> `cpt_o` = 1, 2, 3, 0, 1; `last_o` is high only in the cycle where `cpt_o = 3`.
- Hold: count to 2, then `enable_i = 0` for 4 edges -> `cpt_o` stays 2. Then pulse `init_i` -> 0 on the next edge.
- Reset mid-operation: count to 3, drop `resetb_i` between edges -> `cpt_o = 0` immediately. After release, counting restarts from 0 (first edge gives 1).
- `COMPTEUR_BLOC_SAT_EN` build: 5 enabled edges -> `cpt_o` = 1, 2, 3, 3, 3 with `last_o` held high. Then `init_i` -> 0.
